sha256_block_sequencer: RTL and testbench

Sequences message words into the `preprocessor` padding datapath and hands finished 512-bit blocks to the SHA-256 compression core.
- Accepts 512-bit message words over a valid/ready stream.
- Passes non-final words through raw.
- Routes the final word through `preprocessor`, then decides whether a second padding block is needed and generates it.
- Drives the preprocessor inputs `second_block_flag` and `length512`.
- Marks first/last block boundaries for the core's digest init/finalise.

---
 rtl/sha256_block_sequencer.sv | 158 +++++++++++++++
 tb/tb_sha256_block_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_sequencer.sv
// Feeds message words to the SHA-256 padding datapath and presents 512-bit blocks to the core.
// Optional word-count length check is compiled in with `define SHA_SEQ_LEN_CHECK_EN.
module sha256_block_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  input  logic         in_last,
  input  logic [63:0]  msg_len,
  output logic [511:0] pp_data,
  output logic [63:0]  pp_data_len,
  output logic         pp_second_block_flag,
  output logic         pp_length512,
  input  logic [511:0] pp_block,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         msg_done,
  output logic         len_err
);

  localparam logic [1:0] S_IN    = 2'd0;
  localparam logic [1:0] S_BLK   = 2'd1;
  localparam logic [1:0] S_EXTRA = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [511:0] word_q, word_d;
  logic         last_q, last_d;
  logic [63:0]  len_q, len_d;
  logic         first_pending_q, first_pending_d;
  logic         msg_done_q, msg_done_d;

  logic         need_extra;
  logic         in_hs;
  logic         blk_hs;

  // A second block is needed when the 0x80 marker plus 64-bit length cannot fit
  // behind the data, including the exact-multiple-of-512 case.
  assign need_extra = (len_q[8:0] >= 9'd448) || ((len_q[8:0] == 9'd0) && (len_q != 64'd0));

  assign in_ready  = !rst && (state_q == S_IN);
  assign blk_valid = (state_q == S_BLK) || (state_q == S_EXTRA);
  assign in_hs     = in_valid && in_ready;
  assign blk_hs    = blk_valid && blk_ready;

  assign pp_data              = word_q;
  assign pp_data_len          = len_q;
  assign pp_second_block_flag = (state_q == S_EXTRA);
  assign pp_length512         = (state_q == S_EXTRA) && (len_q[8:0] == 9'd0);

  assign blk_data  = ((state_q == S_EXTRA) || last_q) ? pp_block : word_q;
  assign blk_first = (state_q == S_BLK) && first_pending_q;
  assign blk_last  = (state_q == S_EXTRA) || ((state_q == S_BLK) && last_q && !need_extra);
  assign msg_done  = msg_done_q;

  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    last_d          = last_q;
    len_d           = len_q;
    first_pending_d = first_pending_q;
    msg_done_d      = 1'b0;
    case (state_q)
      S_IN: begin
        if (in_hs) begin
          word_d  = in_data;
          last_d  = in_last;
          if (in_last) len_d = msg_len;
          state_d = S_BLK;
        end
      end
      S_BLK: begin
        if (blk_hs) begin
          first_pending_d = 1'b0;
          if (!last_q) begin
            state_d = S_IN;
          end else if (need_extra) begin
            state_d = S_EXTRA;
          end else begin
            state_d         = S_IN;
            msg_done_d      = 1'b1;
            first_pending_d = 1'b1;
          end
        end
      end
      S_EXTRA: begin
        if (blk_hs) begin
          state_d         = S_IN;
          msg_done_d      = 1'b1;
          first_pending_d = 1'b1;
        end
      end
      default: state_d = S_IN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IN;
      word_q          <= '0;
      last_q          <= 1'b0;
      len_q           <= '0;
      first_pending_q <= 1'b1;
      msg_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_q          <= word_d;
      last_q          <= last_d;
      len_q           <= len_d;
      first_pending_q <= first_pending_d;
      msg_done_q      <= msg_done_d;
    end
  end

  // The length compare is carried out in 65 bits; counters wider than 64 bits add nothing.
  if (CNT_W > 64) begin : g_cnt_w_too_wide
  end

`ifdef SHA_SEQ_LEN_CHECK_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             len_err_q, len_err_d;
  logic [64:0]      exp_words;
  logic [64:0]      seen_words;

  assign exp_words  = (msg_len == 64'd0) ? 65'd1 : ((65'(msg_len) + 65'd511) >> 9);
  assign seen_words = 65'(cnt_q) + 65'd1;

  always_comb begin
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    if (in_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (in_last && (seen_words != exp_words)) len_err_d = 1'b1;
    end
    if (msg_done_d) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer with a behavioural padding preprocessor.
// Build with +define+SHA_SEQ_LEN_CHECK_EN to also cover the length check.
module tb_sha256_block_sequencer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         in_last;
  logic [63:0]  msg_len;
  logic [511:0] pp_data;
  logic [63:0]  pp_data_len;
  logic         pp_second_block_flag;
  logic         pp_length512;
  logic [511:0] pp_block;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         msg_done;
  logic         len_err;

  // Expected entry layout: {first, last, second_block_flag, length512, data}
  logic [515:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic stall_en  = 1'b0;
  logic hold_rdy  = 1'b0;
  int   stall_ctr = 0;

  sha256_block_sequencer #(.CNT_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_data              (in_data),
    .in_last              (in_last),
    .msg_len              (msg_len),
    .pp_data              (pp_data),
    .pp_data_len          (pp_data_len),
    .pp_second_block_flag (pp_second_block_flag),
    .pp_length512         (pp_length512),
    .pp_block             (pp_block),
    .blk_valid            (blk_valid),
    .blk_ready            (blk_ready),
    .blk_data             (blk_data),
    .blk_first            (blk_first),
    .blk_last             (blk_last),
    .msg_done             (msg_done),
    .len_err              (len_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural padding preprocessor.
  function automatic logic [511:0] pp_model(input logic [511:0] data, input logic [63:0] len,
                                            input logic sbf, input logic l512);
    logic [511:0] mask;
    logic [511:0] blk;
    logic [511:0] one;
    int rv;
    rv = int'(len[8:0]);
    one = 512'd1;
    if (sbf) return l512 ? {1'b1, 447'b0, len} : {448'b0, len};
    if (len == 64'd0) return {1'b1, 511'b0};
    if (rv == 0) return data;
    mask = '1;
    mask = mask << (512 - rv);
    blk = (data & mask) | (one << (511 - rv));
    if (rv < 448) blk[63:0] = len;
    return blk;
  endfunction

  always_comb pp_block = pp_model(pp_data, pp_data_len, pp_second_block_flag, pp_length512);

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic push_exp(input logic [511:0] d, input logic first, input logic last,
                          input logic sbf, input logic l512);
    exp_q.push_back({first, last, sbf, l512, d});
  endtask

  task automatic send_word(input logic [511:0] d, input logic last, input logic [63:0] len);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    msg_len  = len;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("in_handshake_timeout", 512'd0, 512'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    msg_len  = $urandom_range(0, 65535);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !blk_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 512'(exp_q.size()), 512'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // blk_ready driver: always ready, held low, or stalled ~5 cycles per block
  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_rdy) begin
        blk_ready = 1'b0;
      end else if (!stall_en) begin
        blk_ready = 1'b1;
        stall_ctr = 0;
      end else if (blk_ready) begin
        blk_ready = 1'b0;
        stall_ctr = 0;
      end else if (blk_valid) begin
        if (stall_ctr >= 5) blk_ready = 1'b1;
        else stall_ctr++;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic         pend_done;
    logic         stalled;
    logic [514:0] held;
    logic [515:0] e;
    pend_done = 1'b0;
    stalled   = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_done = 1'b0;
        stalled   = 1'b0;
      end else begin
        if (msg_done || pend_done) begin
          check("msg_done", 512'(msg_done), 512'(pend_done));
          if (pend_done) check("in_ready_at_done", 512'(in_ready), 512'd1);
        end
        pend_done = 1'b0;
        if (stalled) begin
          check("stall_valid_hold", 512'(blk_valid), 512'd1);
          check("stall_data_hold", 512'({blk_first, blk_last, blk_data}), 512'(held));
        end
        stalled = blk_valid && !blk_ready;
        held    = {blk_first, blk_last, blk_data};
        if (blk_valid && blk_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_block", blk_data, 512'd0);
          end else begin
            e = exp_q.pop_front();
            check("blk_data", blk_data, e[511:0]);
            check("blk_flags", 512'({blk_first, blk_last, pp_second_block_flag, pp_length512}),
                  512'(e[515:512]));
            if (e[514]) pend_done = 1'b1;
          end
        end
      end
    end
  end

  // directed stimulus
  initial begin
    logic [511:0] w0, w1, w3, w4;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    msg_len  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 512'(in_ready), 512'd0);
    check("rst_blk_valid", 512'(blk_valid), 512'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 512'(in_ready), 512'd1);
    check("post_rst_blk_valid", 512'(blk_valid), 512'd0);
    check("post_rst_msg_done", 512'(msg_done), 512'd0);
    check("post_rst_len_err", 512'(len_err), 512'd0);
    @(posedge clk); #1;

    // "abc"
    push_exp({24'h616263, 1'b1, 423'b0, 64'd24}, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word({24'h616263, 488'b0}, 1'b1, 64'd24);
    // empty message; data content must be ignored
    push_exp({1'b1, 511'b0}, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word({512{1'b1}}, 1'b1, 64'd0);
    wait_drain();

    // 448 bits: marker fills bit 63, length goes to a second block
    w3 = {{14{32'hA5A5_0F0F}}, 64'd0};
    push_exp({{14{32'hA5A5_0F0F}}, 1'b1, 63'b0}, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp({448'b0, 64'd448}, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word(w3, 1'b1, 64'd448);
    // 512 bits: raw block, then marker+length block (issued back to back)
    w4 = {16{32'h0123_4567}};
    push_exp(w4, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp({1'b1, 447'b0, 64'd512}, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(w4, 1'b1, 64'd512);
    wait_drain();

    // two words, 1000 bits, stalled core
    stall_en = 1'b1;
    w0 = {16{32'hDEAD_BEEF}};
    w1 = {{15{32'h1357_9BDF}}, 8'h5A, 24'b0};
    push_exp(w0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp({{15{32'h1357_9BDF}}, 8'h5A, 1'b1, 23'b0}, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp({448'b0, 64'd1000}, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word(w0, 1'b0, 64'd0);
    send_word(w1, 1'b1, 64'd1000);
    wait_drain();
    stall_en = 1'b0;
    wait_drain();
    check("len_err_clean", 512'(len_err), 512'd0);

`ifdef SHA_SEQ_LEN_CHECK_EN
    // one word claiming 1000 bits: flagged, but still processed
    push_exp({{15{32'h2468_ACE0}}, 8'hC3, 1'b1, 23'b0}, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp({448'b0, 64'd1000}, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word({{15{32'h2468_ACE0}}, 8'hC3, 24'b0}, 1'b1, 64'd1000);
    wait_drain();
    check("len_err_set", 512'(len_err), 512'd1);
`endif

    // reset while a block is pending
    push_exp(w0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(w0, 1'b0, 64'd0);
    wait_drain();
    hold_rdy = 1'b1;
    send_word(w1, 1'b0, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pending_blk_valid", 512'(blk_valid), 512'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 512'(in_ready), 512'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_rdy = 1'b0;
    @(negedge clk);
    check("mid_rst_blk_valid", 512'(blk_valid), 512'd0);
    check("mid_rst_msg_done", 512'(msg_done), 512'd0);
    check("mid_rst_len_err", 512'(len_err), 512'd0);
    check("mid_rst_in_ready_back", 512'(in_ready), 512'd1);
    @(posedge clk); #1;
    // first_pending must be restored by the reset
    push_exp({24'h616263, 1'b1, 423'b0, 64'd24}, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word({24'h616263, 488'b0}, 1'b1, 64'd24);
    wait_drain();

    check("exp_q_empty", 512'(exp_q.size()), 512'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
